// File: rtl/wb_sdram_pkg.sv
// Shared definitions for the Wishbone-to-SDRAM application-port bridge.
package wb_sdram_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_PUSH  = 3'd1,
    WR_ACK   = 3'd2,
    WR_DRAIN = 3'd3,
    RD_REQ   = 3'd4,
    RD_POP   = 3'd5,
    RD_CAP   = 3'd6,
    RD_ACK   = 3'd7
  } state_t;

  localparam int unsigned DEF_TIMEOUT    = 1024;
  localparam int unsigned DEF_WRITE_HOLD = 16;

endpackage

// File: rtl/wb_sdram_bridge.sv
// Wishbone classic slave driving the SDRAM controller's application FIFO ports,
// one 32-bit word per bus transaction.
module wb_sdram_bridge
  import wb_sdram_pkg::*;
#(
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned WRITE_HOLD = DEF_WRITE_HOLD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wbs_cyc,
  input  logic        i_wbs_stb,
  input  logic        i_wbs_we,
  input  logic [31:0] i_wbs_adr,
  input  logic [31:0] i_wbs_dat,
  input  logic [3:0]  i_wbs_sel,
  output logic [31:0] o_wbs_dat,
  output logic        o_wbs_ack,
  output logic        o_wbs_int,
  input  logic        sdram_ready,
  output logic        app_write_pulse,
  output logic [31:0] app_write_data,
  output logic [3:0]  app_write_mask,
  input  logic        write_fifo_full,
  output logic        app_write_enable,
  output logic        app_read_enable,
  output logic [21:0] app_address,
  output logic        app_read_pulse,
  input  logic [31:0] app_read_data,
  input  logic        read_fifo_empty,
  output state_t      dbg_state
);

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(WRITE_HOLD);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [15:0] drain_cnt;
  logic        wb_req;
  logic        unused_adr_hi;

  // Handshake: a bus request is cyc & stb while ack is low; ack is a one-cycle
  // registered pulse, withheld if cyc has dropped. App pulses last one cycle and
  // read data is taken on the cycle after the pop.
  assign wb_req        = i_wbs_cyc & i_wbs_stb & ~o_wbs_ack;
  assign dbg_state     = state;
  assign unused_adr_hi = &{1'b0, i_wbs_adr[31:22]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      drain_cnt        <= '0;
      o_wbs_dat        <= '0;
      o_wbs_ack        <= 1'b0;
      o_wbs_int        <= 1'b0;
      app_write_pulse  <= 1'b0;
      app_write_data   <= '0;
      app_write_mask   <= '0;
      app_write_enable <= 1'b0;
      app_read_enable  <= 1'b0;
      app_address      <= '0;
      app_read_pulse   <= 1'b0;
    end else begin
      app_write_pulse <= 1'b0;
      app_read_pulse  <= 1'b0;
      o_wbs_ack       <= 1'b0;
      if (!sdram_ready) begin
        state            <= IDLE;
        app_write_enable <= 1'b0;
        app_read_enable  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (app_write_enable) begin
              // Write path still open: further writes go straight in, anything
              // else (bus released or a read) closes it through the drain.
              if (wb_req && i_wbs_we) begin
                app_address <= i_wbs_adr[21:0];
                state       <= WR_PUSH;
              end else if (!i_wbs_cyc || wb_req) begin
                drain_cnt <= HOLD_LOAD;
                state     <= WR_DRAIN;
              end
            end else if (wb_req) begin
              app_address <= i_wbs_adr[21:0];
              if (i_wbs_we) begin
                state <= WR_PUSH;
              end else begin
                o_wbs_int       <= 1'b0;
                tmo_cnt         <= '0;
                app_read_enable <= 1'b1;
                state           <= RD_REQ;
              end
            end
          end
          WR_PUSH: begin
            if (!write_fifo_full) begin
              app_write_pulse  <= 1'b1;
              app_write_data   <= i_wbs_dat;
              app_write_mask   <= ~i_wbs_sel;
              app_write_enable <= 1'b1;
              state            <= WR_ACK;
            end
          end
          WR_ACK: begin
            o_wbs_ack <= i_wbs_cyc;
            if (i_wbs_cyc) begin
              state <= IDLE;
            end else begin
              drain_cnt <= HOLD_LOAD;
              state     <= WR_DRAIN;
            end
          end
          WR_DRAIN: begin
            if (wb_req && i_wbs_we) begin
              app_address <= i_wbs_adr[21:0];
              drain_cnt   <= HOLD_LOAD;
              state       <= WR_PUSH;
            end else if (drain_cnt <= 16'd1) begin
              drain_cnt        <= '0;
              app_write_enable <= 1'b0;
              state            <= IDLE;
            end else begin
              drain_cnt <= drain_cnt - 16'd1;
            end
          end
          RD_REQ: begin
            if (!read_fifo_empty) begin
              app_read_pulse <= 1'b1;
              state          <= RD_POP;
            end else if (tmo_cnt >= TMO_LAST) begin
              o_wbs_int       <= 1'b1;
              o_wbs_dat       <= '0;
              o_wbs_ack       <= i_wbs_cyc;
              app_read_enable <= 1'b0;
              state           <= RD_ACK;
            end else if (tmo_cnt != 16'hFFFF) begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
          RD_POP: begin
            state <= RD_CAP;
          end
          RD_CAP: begin
            o_wbs_dat       <= app_read_data;
            o_wbs_ack       <= i_wbs_cyc;
            app_read_enable <= 1'b0;
            state           <= RD_ACK;
          end
          RD_ACK: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Self-checking bench for wb_sdram_bridge: vector table plus hand-written
// sequences for stall, reset and abort corner cases.
module tb_wb_sdram_bridge;
  import wb_sdram_pkg::*;

  localparam int TMO  = 1024;
  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wbs_cyc, i_wbs_stb, i_wbs_we;
  logic [31:0] i_wbs_adr, i_wbs_dat;
  logic [3:0]  i_wbs_sel;
  logic [31:0] o_wbs_dat;
  logic        o_wbs_ack, o_wbs_int;
  logic        sdram_ready;
  logic        app_write_pulse;
  logic [31:0] app_write_data;
  logic [3:0]  app_write_mask;
  logic        write_fifo_full;
  logic        app_write_enable, app_read_enable;
  logic [21:0] app_address;
  logic        app_read_pulse;
  logic [31:0] app_read_data;
  logic        read_fifo_empty;
  state_t      dbg_state;

  wb_sdram_bridge #(.TIMEOUT(TMO), .WRITE_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst),
    .i_wbs_cyc(i_wbs_cyc), .i_wbs_stb(i_wbs_stb), .i_wbs_we(i_wbs_we),
    .i_wbs_adr(i_wbs_adr), .i_wbs_dat(i_wbs_dat), .i_wbs_sel(i_wbs_sel),
    .o_wbs_dat(o_wbs_dat), .o_wbs_ack(o_wbs_ack), .o_wbs_int(o_wbs_int),
    .sdram_ready(sdram_ready),
    .app_write_pulse(app_write_pulse), .app_write_data(app_write_data),
    .app_write_mask(app_write_mask), .write_fifo_full(write_fifo_full),
    .app_write_enable(app_write_enable), .app_read_enable(app_read_enable),
    .app_address(app_address), .app_read_pulse(app_read_pulse),
    .app_read_data(app_read_data), .read_fifo_empty(read_fifo_empty),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          stall;
    logic [31:0] rdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata;
    logic        exp_int;
    int          exp_lat;
    int          exp_pulses;
    logic        keep;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [57:0] wr_exp_q[$];
  logic [31:0] rd_exp_q[$];
  logic [31:0] rd_word = 32'h0;

  // ---------------- controller read-FIFO model ----------------
  logic pop_d;
  always @(posedge clk) begin
    pop_d = app_read_pulse;
    #1 app_read_data = pop_d ? rd_word : 32'hDEAD_BEEF;
  end

  // ---------------- protocol monitor ----------------
  int   push_cnt = 0;
  int   pop_cnt  = 0;
  int   mon_errs = 0;
  logic wp_d = 1'b0;
  logic rp_d = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (app_read_enable && app_write_enable) begin
        mon_errs++;
        $display("FAIL enables_exclusive: both enables high at %0t", $time);
      end
      if ((app_write_pulse && wp_d) || (app_read_pulse && rp_d)) begin
        mon_errs++;
        $display("FAIL pulse_width: pulse high two cycles at %0t", $time);
      end
      if (app_write_pulse) push_cnt++;
      if (app_read_pulse) pop_cnt++;
    end
    wp_d = app_write_pulse;
    rp_d = app_read_pulse;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel,
                              int stall, logic [31:0] rdata, logic [3:0] exp_mask,
                              logic [31:0] exp_rdata, logic exp_int, int exp_lat,
                              int exp_pulses, logic keep);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.stall = stall; v.rdata = rdata;
    v.exp_mask = exp_mask; v.exp_rdata = exp_rdata; v.exp_int = exp_int;
    v.exp_lat = exp_lat; v.exp_pulses = exp_pulses; v.keep = keep;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input vec_t v);
    @(negedge clk);
    rd_word   = v.rdata;
    i_wbs_cyc = 1'b1;
    i_wbs_stb = 1'b1;
    i_wbs_we  = v.we;
    i_wbs_adr = v.adr;
    i_wbs_dat = v.dat;
    i_wbs_sel = v.sel;
    write_fifo_full = v.we && (v.stall > 0);
    read_fifo_empty = 1'b1;
    if (v.we) wr_exp_q.push_back({v.adr[21:0], v.dat, v.exp_mask});
    else      rd_exp_q.push_back(v.exp_rdata);
  endtask

  // Edge n = 0 is the edge that accepts the request.
  task automatic await_ack(input vec_t v);
    int p0, r0;
    bit acked, popped;
    acked  = 1'b0;
    popped = 1'b0;
    p0 = push_cnt;
    r0 = pop_cnt;
    for (int n = 0; n < 2000 && !acked; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (app_write_pulse) begin
        if (wr_exp_q.size() == 0) check("wr_unexpected_push", 1, 0);
        else check("wr_push_fields", {app_address, app_write_data, app_write_mask}, wr_exp_q.pop_front());
      end
      if (app_read_pulse) begin
        popped = 1'b1;
        read_fifo_empty = 1'b1;
        check("rd_pop_addr", app_address, v.adr[21:0]);
      end else if (!v.we && !popped) begin
        read_fifo_empty = (n + 1 <= v.stall);
      end
      if (v.we) write_fifo_full = (n + 1 <= v.stall);
      if (o_wbs_ack) begin
        acked = 1'b1;
        check("ack_latency", n, v.exp_lat);
        if (v.we) begin
          check("wr_enable_held", app_write_enable, 1);
        end else begin
          if (rd_exp_q.size() == 0) check("rd_unexpected_ack", 1, 0);
          else check("rd_data", o_wbs_dat, rd_exp_q.pop_front());
          check("rd_int", o_wbs_int, v.exp_int);
          check("rd_enable_dropped", app_read_enable, 0);
        end
        i_wbs_stb = 1'b0;
        if (!v.keep) i_wbs_cyc = 1'b0;
        write_fifo_full = 1'b0;
        read_fifo_empty = 1'b1;
      end
    end
    if (!acked) begin
      check("ack_timeout", 0, 1);
      i_wbs_stb = 1'b0;
      i_wbs_cyc = 1'b0;
    end
    check("push_count", push_cnt - p0, v.we ? v.exp_pulses : 0);
    check("pop_count", pop_cnt - r0, v.we ? 0 : v.exp_pulses);
  endtask

  task automatic run_vec(input vec_t v, input bit chk_drain);
    int hold;
    drive_req(v);
    await_ack(v);
    if (v.we && !v.keep && chk_drain) begin
      hold = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (!app_write_enable) break;
        hold++;
      end
      check("drain_hold", hold, HOLD);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (k < 200 && (app_write_enable || app_read_enable || dbg_state != IDLE)) begin
      @(negedge clk);
      k++;
    end
    check("reach_idle", k < 200, 1);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[9];
  vec_t v;
  int   bad, acks, r0;

  initial begin
    vecs[0] = mk(1, 32'h0001_2345, 32'hA5A5_5A5A, 4'b0011, 0,      32'h0,         4'b1100, 32'h0,         0, 2,    1, 0);
    vecs[1] = mk(1, 32'hFFC0_0010, 32'h1234_5678, 4'b1111, 5,      32'h0,         4'b0000, 32'h0,         0, 7,    1, 0);
    vecs[2] = mk(0, 32'h0000_0100, 32'h0,         4'b1111, 10,     32'hCAFE_F00D, 4'b0000, 32'hCAFE_F00D, 0, 13,   1, 0);
    vecs[3] = mk(0, 32'h003F_FFFF, 32'h0,         4'b1111, 0,      32'h0BAD_C0DE, 4'b0000, 32'h0BAD_C0DE, 0, 3,    1, 0);
    vecs[4] = mk(0, 32'h0000_0200, 32'h0,         4'b1111, 100000, 32'h7777_7777, 4'b0000, 32'h0,         1, TMO,  0, 0);
    vecs[5] = mk(0, 32'h0000_0300, 32'h0,         4'b1111, 2,      32'h1357_9BDF, 4'b0000, 32'h1357_9BDF, 0, 5,    1, 0);
    vecs[6] = mk(1, 32'h0000_0400, 32'hFEED_BEEF, 4'b1000, 0,      32'h0,         4'b0111, 32'h0,         0, 2,    1, 1);
    vecs[7] = mk(0, 32'h0000_0500, 32'h0,         4'b1111, 0,      32'h2468_ACE0, 4'b0000, 32'h2468_ACE0, 0, 20,   1, 0);
    vecs[8] = mk(1, 32'h0012_0040, 32'h0F0F_F0F0, 4'b0100, 1,      32'h0,         4'b1011, 32'h0,         0, 3,    1, 0);

    // ---------------- reset ----------------
    rst = 1'b0; sdram_ready = 1'b1;
    i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0; i_wbs_we = 1'b0;
    i_wbs_adr = '0; i_wbs_dat = '0; i_wbs_sel = '0;
    write_fifo_full = 1'b0; read_fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_wbs_dat, o_wbs_ack, o_wbs_int, app_write_pulse, app_write_data,
                            app_write_mask, app_write_enable, app_read_enable, app_address,
                            app_read_pulse, dbg_state}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Controller not ready: request stalls, then completes two edges after ready.
    v = mk(1, 32'h0000_0ABC, 32'h1122_3344, 4'b1111, 0, 32'h0, 4'b0000, 32'h0, 0, 2, 1, 0);
    sdram_ready = 1'b0;
    drive_req(v);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (app_write_pulse || o_wbs_ack) bad++;
    end
    check("not_ready_stall", bad, 0);
    sdram_ready = 1'b1;
    await_ack(v);
    wait_idle();

    // ---------------- vector table ----------------
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], 1'b1);
      if (!vecs[i].keep) wait_idle();
    end

    // Write accepted in the middle of a drain restarts the hold.
    v = mk(1, 32'h0000_0600, 32'hAAAA_0001, 4'b0001, 0, 32'h0, 4'b1110, 32'h0, 0, 2, 1, 0);
    run_vec(v, 1'b0);
    repeat (5) @(negedge clk);
    check("drain_active", {dbg_state, app_write_enable}, {WR_DRAIN, 1'b1});
    v = mk(1, 32'h0000_0604, 32'hAAAA_0002, 4'b0110, 0, 32'h0, 4'b1001, 32'h0, 0, 2, 1, 0);
    run_vec(v, 1'b1);
    wait_idle();

    // Bus cycle dropped mid-read: read finishes internally, no ack.
    rd_word = 32'h5555_AAAA;
    r0 = pop_cnt;
    @(negedge clk);
    i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = 1'b0; i_wbs_adr = 32'h0000_0700;
    read_fifo_empty = 1'b0;
    @(negedge clk);
    i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_wbs_ack) acks++;
      if (app_read_pulse) read_fifo_empty = 1'b1;
    end
    read_fifo_empty = 1'b1;
    check("abort_no_ack", acks, 0);
    check("abort_one_pop", pop_cnt - r0, 1);
    check("abort_idle", {dbg_state, app_read_enable}, {IDLE, 1'b0});

    // Reset while waiting in RD_REQ.
    @(negedge clk);
    i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = 1'b0; i_wbs_adr = 32'h0000_0800;
    repeat (3) @(negedge clk);
    check("in_rd_req", {dbg_state, app_read_enable}, {RD_REQ, 1'b1});
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_read", {o_wbs_dat, o_wbs_ack, o_wbs_int, app_write_pulse, app_write_data,
                            app_write_mask, app_write_enable, app_read_enable, app_address,
                            app_read_pulse, dbg_state}, 0);
    rst = 1'b1;
    i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0;
    repeat (2) @(negedge clk);
    v = mk(1, 32'h0002_0002, 32'h600D_CAFE, 4'b1010, 0, 32'h0, 4'b0101, 32'h0, 0, 2, 1, 0);
    run_vec(v, 1'b1);
    wait_idle();

    // ---------------- report ----------------
    check("monitor_violations", mon_errs, 0);
    check("wr_queue_empty", wr_exp_q.size(), 0);
    check("rd_queue_empty", rd_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
